// File: rtl/mac_feed_pkg.sv
// mac_feed_pkg: shared states, precision codes and helpers for the MAC operand feeder
package mac_feed_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DONE} state_t;
  localparam logic [1:0] PREC_8 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_2 = 2'b10;
  localparam logic [1:0] PREC_4X = 2'b11;
  localparam int FLUSH_CYC = 2;
  function automatic logic [3:0] prec_bits(input logic [1:0] code);
    return code == PREC_8 ? 4'd8 : code == PREC_2 ? 4'd2 : 4'd4;
  endfunction
endpackage

// File: rtl/mac_wgt_lane_mux.sv
// mac_wgt_lane_mux: places the reduced-precision weight in its phase lane and sign-extends the activation
module mac_wgt_lane_mux
  import mac_feed_pkg::*;
(
  input  logic [7:0] wgt,
  input  logic [7:0] act,
  input  logic [2:0] phase,
  input  logic [1:0] prec,
  output logic [7:0] lane_wgt,
  output logic [7:0] ext_act
);
  logic [1:0] lsh;
  logic [7:0] field;
  // phase rounded down to a multiple of the precision width is the lane's bit offset
  always_comb begin
    lsh = prec == PREC_8 ? 2'd3 : (prec == PREC_4 || prec == PREC_4X) ? 2'd2 : 2'd1;
    field = prec == PREC_8 ? wgt : prec == PREC_2 ? {6'd0, wgt[1:0]} : {4'd0, wgt[3:0]};
    lane_wgt = field << ((phase >> lsh) << lsh);
    ext_act = prec == PREC_8 ? act : prec == PREC_2 ? {{6{act[1]}}, act[1:0]} : {{4{act[3]}}, act[3:0]};
  end
endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: feeds (act, wgt) pairs to a bit-serial MAC; optional MAC_FEED_STALL_CNT_EN adds a stall counter
module mac_operand_feeder
  import mac_feed_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [1:0]       cfg_prec_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_act_i,
  input  logic [7:0]       op_wgt_i,
  output logic             mac_rstn_o,
  output logic             mac_en_o,
  output logic [7:0]       mac_act_o,
  output logic [7:0]       mac_wgt_o,
  output logic [1:0]       mac_prec_o,
  output logic             busy_o,
  output logic             vec_done_o,
  output logic [15:0]      stall_cnt_o
);
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_d;
  logic [2:0] phase_q, bit_q, bit_d;
  logic [1:0] fl_q, fl_d;
  logic full_q, full_d, en_d, ready_d, hs, last, all_in;
  logic [3:0] bits;
  logic [7:0] lane_wgt, ext_act;
  assign bits = prec_bits(mac_prec_o);
  assign hs = op_ready_o & op_valid_i;
  assign last = full_q && ({1'b0, bit_q} == bits - 4'd1);
  assign all_in = cnt_q == len_q;
  mac_wgt_lane_mux u_mux (
    .wgt(op_wgt_i),
    .act(op_act_i),
    .phase(phase_q),
    .prec(mac_prec_o),
    .lane_wgt(lane_wgt),
    .ext_act(ext_act)
  );
  // next state, next MAC enable and pair/bit/flush bookkeeping
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    full_d = 1'b0;
    bit_d = bit_q;
    cnt_d = cnt_q;
    fl_d = fl_q;
    unique case (state_q)
      IDLE: state_d = start_i ? CLEAR : IDLE;
      CLEAR: begin
        bit_d = 3'd0;
        cnt_d = '0;
        fl_d = 2'd0;
        state_d = len_q == '0 ? FLUSH : FEED;
        en_d = len_q == '0;
      end
      FEED: begin
        full_d = hs || (full_q && !last);
        en_d = full_d;
        bit_d = hs ? 3'd0 : bit_q + 3'(full_q);
        cnt_d = cnt_q + LEN_W'(hs);
        if (last && all_in) begin
          state_d = FLUSH;
          en_d = 1'b1;
          fl_d = 2'd0;
        end
      end
      FLUSH: begin
        fl_d = fl_q + 2'd1;
        en_d = fl_q + 2'd1 < 2'(FLUSH_CYC);
        state_d = fl_q == 2'(FLUSH_CYC) ? DONE : FLUSH;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == FEED && cnt_d != len_q && (!full_d || {1'b0, bit_d} == bits - 4'd1);
  end
  // state, counters and registered MAC-side outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      len_q <= '0;
      cnt_q <= '0;
      phase_q <= 3'd0;
      bit_q <= 3'd0;
      fl_q <= 2'd0;
      full_q <= 1'b0;
      mac_prec_o <= 2'd0;
      mac_rstn_o <= 1'b0;
      mac_en_o <= 1'b0;
      mac_act_o <= 8'd0;
      mac_wgt_o <= 8'd0;
      op_ready_o <= 1'b0;
      busy_o <= 1'b0;
      vec_done_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      fl_q <= fl_d;
      full_q <= full_d;
      phase_q <= (state_q == CLEAR ? 3'd0 : phase_q) + 3'(en_d);
      if (state_q == IDLE && start_i) begin
        len_q <= len_i;
        mac_prec_o <= cfg_prec_i;
      end
      mac_rstn_o <= state_d != CLEAR;
      mac_en_o <= en_d;
      mac_act_o <= hs ? ext_act : full_d ? mac_act_o : 8'd0;
      mac_wgt_o <= hs ? lane_wgt : full_d ? mac_wgt_o : 8'd0;
      op_ready_o <= ready_d;
      busy_o <= state_d != IDLE;
      vec_done_o <= state_d == DONE;
    end
  end
`ifdef MAC_FEED_STALL_CNT_EN
  // saturating count of FEED cycles left without a MAC enable
  always_ff @(posedge clk) begin
    if (!rstn || state_q == CLEAR) stall_cnt_o <= 16'd0;
    else if (state_q == FEED && state_d == FEED && !en_d && stall_cnt_o != 16'hFFFF) stall_cnt_o <= stall_cnt_o + 16'd1;
  end
`else
  assign stall_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: directed and random vectors against a dot-product and operand-trace model
module tb_mac_operand_feeder;
  logic clk = 1'b0, rstn = 1'b0, start_i = 1'b0, op_valid_i = 1'b0;
  logic [7:0] len_i = 8'd0, op_act_i = 8'd0, op_wgt_i = 8'd0;
  logic [1:0] cfg_prec_i = 2'd0;
  logic op_ready_o, mac_rstn_o, mac_en_o, busy_o, vec_done_o;
  logic [7:0] mac_act_o, mac_wgt_o;
  logic [1:0] mac_prec_o;
  logic [15:0] stall_cnt_o;
  int n_cmp = 0, n_err = 0;
  logic [7:0] pa[$], pw[$];
  int pg[$];

  always #5 clk = ~clk;

  mac_operand_feeder #(.LEN_W(8)) dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .len_i(len_i), .cfg_prec_i(cfg_prec_i),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_act_i(op_act_i), .op_wgt_i(op_wgt_i),
    .mac_rstn_o(mac_rstn_o), .mac_en_o(mac_en_o), .mac_act_o(mac_act_o), .mac_wgt_o(mac_wgt_o),
    .mac_prec_o(mac_prec_o), .busy_o(busy_o), .vec_done_o(vec_done_o), .stall_cnt_o(stall_cnt_o)
  );

  function automatic int sx(input logic [7:0] v, input int bits);
    int m, u;
    m = 1 << bits;
    u = int'(v) & (m - 1);
    return u >= m / 2 ? u - m : u;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic clr();
    pa.delete(); pw.delete(); pg.delete();
  endtask

  task automatic add(input logic [7:0] a, input logic [7:0] w, input int g);
    pa.push_back(a); pw.push_back(w); pg.push_back(g);
  endtask

  task automatic run_vec(input logic [1:0] prec, input int abort_after);
    int bits, len, mask, cyc, acc, gap, sum_gap, ens, exp_lat, exp_stall, mbit, lane;
    logic signed [63:0] ref_sum, mac_res;
    logic [7:0] ea[$], ew[$];
    logic hs, done;
    len = pa.size();
    bits = prec == 2'b00 ? 8 : prec == 2'b10 ? 2 : 4;
    mask = (1 << bits) - 1;
    ref_sum = 0;
    sum_gap = 0;
    for (int p = 0; p < len; p++) begin
      ref_sum += sx(pa[p], bits) * sx(pw[p], bits);
      sum_gap += pg[p];
      for (int j = 0; j < bits; j++) begin
        lane = ((p * bits + j) % 8) / bits;
        ea.push_back(8'(sx(pa[p], bits)));
        ew.push_back(8'((int'(pw[p]) & mask) << (lane * bits)));
      end
    end
    repeat (2) begin ea.push_back(8'd0); ew.push_back(8'd0); end
    exp_lat = len == 0 ? 5 : 6 + len * bits + sum_gap;
`ifdef MAC_FEED_STALL_CNT_EN
    exp_stall = sum_gap;
`else
    exp_stall = 0;
`endif
    start_i = 1'b1; len_i = 8'(len); cfg_prec_i = prec;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1;
    chk("clear_mac_rstn", mac_rstn_o, 0);
    chk("clear_busy", busy_o, 1);
    chk("clear_prec", mac_prec_o, prec);
    mac_res = 0; mbit = 0; acc = 0; ens = 0; done = 1'b0;
    gap = len > 0 ? pg[0] : 0;
    while (!done && cyc < exp_lat + 16) begin
      op_valid_i = acc < len && gap == 0;
      op_act_i = acc < len ? pa[acc] : 8'($urandom);
      op_wgt_i = acc < len ? pw[acc] : 8'($urandom);
      if (acc < len && gap > 0 && op_ready_o) gap--;
      start_i = 1'($urandom); len_i = 8'($urandom); cfg_prec_i = 2'($urandom);
      if (acc == len) chk("ready_low_all_in", op_ready_o, 0);
      hs = op_valid_i && op_ready_o;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin acc++; gap = acc < len ? pg[acc] : 0; end
      if (mac_rstn_o !== 1'b1) begin
        mac_res = 0; mbit = 0;
      end else if (mac_en_o) begin
        ens++;
        if (ea.size() > 0) chk("operands", {mac_act_o, mac_wgt_o}, {ea.pop_front(), ew.pop_front()});
        else chk("extra_en", ens, len * bits + 2);
        lane = mbit / bits;
        if (mbit % bits == bits - 1) mac_res += $signed(mac_act_o) * sx(8'(mac_wgt_o >> (lane * bits)), bits);
        mbit = (mbit + 1) % 8;
      end
      if (vec_done_o === 1'b1) begin
        done = 1'b1;
        chk("done_cycle", cyc, exp_lat);
        chk("en_cycles", ens, len * bits + 2);
        chk("result", mac_res, ref_sum);
        chk("stall_cnt", stall_cnt_o, exp_stall);
        chk("done_busy", busy_o, 1);
      end
      if (abort_after >= 0 && acc == abort_after) begin
        rstn = 1'b0; start_i = 1'b0; op_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_mac_rstn", mac_rstn_o, 0);
        chk("rst_ready", op_ready_o, 0);
        chk("rst_en", mac_en_o, 0);
        chk("rst_wgt", mac_wgt_o, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", mac_rstn_o, 1);
        return;
      end
    end
    chk("done_seen", done, 1);
    start_i = 1'b0; op_valid_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", busy_o, 0);
    chk("idle_done", vec_done_o, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mac_rstn", mac_rstn_o, 0);
    chk("reset_en", mac_en_o, 0);
    chk("reset_ready", op_ready_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", vec_done_o, 0);
    chk("reset_act", mac_act_o, 0);
    chk("reset_wgt", mac_wgt_o, 0);
    chk("reset_prec", mac_prec_o, 0);
    chk("reset_stall", stall_cnt_o, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rstn_rise", mac_rstn_o, 1);
    clr(); add(8'd3, 8'd5, 0); run_vec(2'b00, -1);
    clr(); add(8'd2, 8'd3, 0); add(8'hff, 8'hfe, 0); run_vec(2'b01, -1);
    clr(); repeat (4) add(8'd1, 8'd1, 0); run_vec(2'b10, -1);
    clr(); add(8'($urandom), 8'($urandom), 0); add(8'($urandom), 8'($urandom), 3); run_vec(2'b00, -1);
    clr(); run_vec(2'b00, -1);
    clr(); repeat (3) add(8'($urandom), 8'($urandom), 0); run_vec(2'b00, 2);
    clr(); repeat (3) add(8'($urandom), 8'($urandom), 0); run_vec(2'b01, -1);
    for (int v = 0; v < 12; v++) begin
      clr();
      n = $urandom_range(0, 6);
      repeat (n) add(8'($urandom), 8'($urandom), $urandom_range(0, 2));
      run_vec(2'($urandom), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
